// File: rtl/csa_accumulator.sv
// csa_accumulator: accumulates a stream of LEN-bit operands in redundant
// (partial-sum, carry) form with one 3:2 compression per accepted operand.
// On the closing operand it resolves ps + (cs << 1) with a CHUNK-bit-wide
// carry-propagate adder, one slice per cycle. The binary sum (mod 2^LEN)
// is then presented on a valid/ready output.
//
// Handshakes (valid/ready):
//   - A transfer happens on a rising edge where valid and ready are both high.
//   - Neither side may make ready depend combinationally on valid.
//   - A producer holding valid keeps its payload stable until the transfer.
//   - Here ready/valid outputs decode from the FSM state only.
module csa_accumulator #(
  parameter int LEN   = 256,
  parameter int CHUNK = 64
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic [LEN-1:0] op_i,
  input  logic           op_valid_i,
  input  logic           op_last_i,
  output logic           op_ready_o,
  output logic [LEN-1:0] sum_o,
  output logic           sum_valid_o,
  input  logic           sum_ready_i,
  output logic           busy_o
);

  localparam int NCHUNK = LEN / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  // Slices must tile the word exactly, otherwise the resolve walk would
  // leave the top bits unwritten.
  generate
    if ((LEN % CHUNK) != 0 || CHUNK < 1) begin : g_bad_chunk
      $error("csa_accumulator: LEN must be a non-zero multiple of CHUNK");
    end
  endgenerate

  // FSM state. Kept as a named enum so checkers can bind to state_q.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACC     = 2'd1,
    S_RESOLVE = 2'd2,
    S_OUT     = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Datapath registers and their next-state values.
  logic [LEN-1:0] ps_q, ps_d;
  logic [LEN-1:0] cs_q, cs_d;
  logic [LEN-1:0] sum_q, sum_d;
  logic [KW-1:0]  k_q, k_d;
  logic           carry_q, carry_d;

  // Carry vector aligned to its weight. The carry out of bit LEN-1 falls off
  // here, which is what makes the accumulation wrap mod 2^LEN.
  logic [LEN-1:0] c_vec;
  assign c_vec = {cs_q[LEN-2:0], 1'b0};

  // Operand handshake: ready is only ever high in ACC.
  logic op_hs;
  assign op_hs = op_valid_i & (state_q == S_ACC);

  // Current CPA slice: ps slice + shifted-carry slice + ripple carry.
  logic [CHUNK-1:0] ps_slice;
  logic [CHUNK-1:0] c_slice;
  logic [CHUNK:0]   cpa;
  assign ps_slice = ps_q[k_q*CHUNK +: CHUNK];
  assign c_slice  = c_vec[k_q*CHUNK +: CHUNK];
  assign cpa      = {1'b0, ps_slice} + {1'b0, c_slice} + {{CHUNK{1'b0}}, carry_q};

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = S_ACC;
      S_ACC:     if (op_hs && op_last_i) state_d = S_RESOLVE;
      S_RESOLVE: if (k_q == K_LAST) state_d = S_OUT;
      S_OUT:     if (sum_ready_i) state_d = S_ACC;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode; depends on state only.
  always_comb begin
    op_ready_o  = 1'b0;
    sum_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      S_ACC:     op_ready_o = 1'b1;
      S_RESOLVE: busy_o     = 1'b1;
      S_OUT: begin
        sum_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum_o = sum_q;

  // Datapath next-state: 3:2 compression in ACC, slice-wise CPA in RESOLVE,
  // clear of the redundant pair when the sum is taken in OUT.
  always_comb begin
    ps_d    = ps_q;
    cs_d    = cs_q;
    sum_d   = sum_q;
    k_d     = k_q;
    carry_d = carry_q;
    case (state_q)
      S_ACC: begin
        if (op_hs) begin
          ps_d = op_i ^ ps_q ^ c_vec;
          cs_d = (op_i & ps_q) | (op_i & c_vec) | (ps_q & c_vec);
          if (op_last_i) begin
            k_d     = '0;
            carry_d = 1'b0;
          end
        end
      end
      S_RESOLVE: begin
        sum_d[k_q*CHUNK +: CHUNK] = cpa[CHUNK-1:0];
        // The carry out of the top slice is simply never consumed.
        carry_d = cpa[CHUNK];
        k_d     = (k_q == K_LAST) ? '0 : k_q + KW'(1);
      end
      S_OUT: begin
        if (sum_ready_i) begin
          ps_d = '0;
          cs_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any accumulation in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ps_q    <= '0;
      cs_q    <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      cs_q    <= cs_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed testbench for csa_accumulator with hand-computed sums.
module tb_csa_accumulator;

  localparam int LEN    = 256;
  localparam int CHUNK  = 64;
  localparam int NCHUNK = LEN / CHUNK;

  logic           clk;
  logic           rst_n;
  logic [LEN-1:0] op;
  logic           op_valid;
  logic           op_last;
  logic           op_ready;
  logic [LEN-1:0] sum;
  logic           sum_valid;
  logic           sum_ready;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;

  csa_accumulator #(.LEN(LEN), .CHUNK(CHUNK)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .op_i        (op),
    .op_valid_i  (op_valid),
    .op_last_i   (op_last),
    .op_ready_o  (op_ready),
    .sum_o       (sum),
    .sum_valid_o (sum_valid),
    .sum_ready_i (sum_ready),
    .busy_o      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [LEN-1:0] exp_q[$];

  task automatic check(input string tag, input logic [LEN-1:0] got, input logic [LEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All driving and sampling happens on the falling edge.
  task automatic send_op(input logic [LEN-1:0] val, input logic last);
    int n = 0;
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("op_ready_wait", {{(LEN-1){1'b0}}, op_ready}, 1);
    op       = val;
    op_last  = last;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    op_last  = 1'b0;
    op       = '0;
  endtask

  // Called at the falling edge right after the last operand was accepted.
  // Counting the accepting edge as the first, sum_valid rises on edge
  // NCHUNK+1; until then the block is busy and refuses operands.
  task automatic wait_sum(input string tag);
    logic [LEN-1:0] exp;
    exp = exp_q.pop_front();
    check({tag, "_lat0_valid"}, {{(LEN-1){1'b0}}, sum_valid}, 0);
    for (int i = 1; i < NCHUNK; i++) begin
      @(negedge clk);
      check({tag, "_lat_valid"}, {{(LEN-1){1'b0}}, sum_valid}, 0);
      check({tag, "_lat_ready"}, {{(LEN-1){1'b0}}, op_ready}, 0);
      check({tag, "_lat_busy"},  {{(LEN-1){1'b0}}, busy}, 1);
    end
    @(negedge clk);
    check({tag, "_valid"}, {{(LEN-1){1'b0}}, sum_valid}, 1);
    check({tag, "_sum"}, sum, exp);
  endtask

  // Take the presented sum and confirm ACC is re-entered one cycle later.
  task automatic take_sum(input string tag);
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    check({tag, "_ready_after"}, {{(LEN-1){1'b0}}, op_ready}, 1);
    check({tag, "_valid_after"}, {{(LEN-1){1'b0}}, sum_valid}, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_op_ready"},  {{(LEN-1){1'b0}}, op_ready}, 0);
    check({tag, "_sum_valid"}, {{(LEN-1){1'b0}}, sum_valid}, 0);
    check({tag, "_busy"},      {{(LEN-1){1'b0}}, busy}, 0);
    check({tag, "_sum"},       sum, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [LEN-1:0] all_ones;
  logic [LEN-1:0] held;

  initial begin
    rst_n     = 1'b0;
    op        = '0;
    op_valid  = 1'b0;
    op_last   = 1'b0;
    sum_ready = 1'b0;
    all_ones  = '1;

    // Reset state, then release: op_ready rises one cycle after release.
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    check("release_ready0", {{(LEN-1){1'b0}}, op_ready}, 0);
    @(negedge clk);
    check("release_ready1", {{(LEN-1){1'b0}}, op_ready}, 1);

    // 1: 1+2+3 = 6
    exp_q.push_back(256'd6);
    send_op(256'd1, 1'b0);
    send_op(256'd2, 1'b0);
    send_op(256'd3, 1'b1);
    wait_sum("t1");
    take_sum("t1");

    // 2: five times 2^256-1 wraps to 2^256-5
    exp_q.push_back({{248{1'b1}}, 8'hFB});
    for (int i = 0; i < 5; i++) send_op(all_ones, i == 4);
    wait_sum("t2");
    take_sum("t2");

    // 3: single operand, then 7+8 from a cleared state
    exp_q.push_back(256'hDEAD);
    send_op(256'hDEAD, 1'b1);
    wait_sum("t3a");
    take_sum("t3a");
    exp_q.push_back(256'd15);
    send_op(256'd7, 1'b0);
    send_op(256'd8, 1'b1);
    wait_sum("t3b");
    take_sum("t3b");

    // 4: carries crossing slice boundaries
    exp_q.push_back({191'd0, 1'b1, 64'd0});
    send_op({192'd0, {64{1'b1}}}, 1'b0);
    send_op(256'd1, 1'b1);
    wait_sum("t4a");
    take_sum("t4a");
    exp_q.push_back({63'd0, 1'b1, 192'd0});
    send_op({64'd0, {192{1'b1}}}, 1'b0);
    send_op(256'd1, 1'b1);
    wait_sum("t4b");
    take_sum("t4b");

    // 5: back-pressure in OUT with operands offered the whole time
    exp_q.push_back(256'd30);
    send_op(256'd10, 1'b0);
    send_op(256'd20, 1'b1);
    wait_sum("t5");
    held     = 256'd30;
    op       = 256'h55;
    op_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold_sum", sum, held);
      check("t5_hold_valid", {{(LEN-1){1'b0}}, sum_valid}, 1);
      check("t5_hold_ready", {{(LEN-1){1'b0}}, op_ready}, 0);
    end
    op_valid = 1'b0;
    op       = '0;
    take_sum("t5");
    exp_q.push_back(256'd1);
    send_op(256'd1, 1'b1);
    wait_sum("t5b");
    take_sum("t5b");

    // 6: reset during RESOLVE at slice k=2 aborts the sum
    send_op(256'd11, 1'b0);
    send_op(256'd22, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("t6_rst");
    @(negedge clk);
    check("t6_ready", {{(LEN-1){1'b0}}, op_ready}, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_no_valid", {{(LEN-1){1'b0}}, sum_valid}, 0);
    end
    exp_q.push_back(256'd9);
    send_op(256'd4, 1'b0);
    send_op(256'd5, 1'b1);
    wait_sum("t6");
    take_sum("t6");

    check("scoreboard_empty", LEN'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
